// File: rtl/rrat_commit.sv
// Retirement RAT: committed arch->phys mapping plus a committed copy of the free list.
// Retires up to N in-order instructions per cycle and releases each overwritten PRN.
module rrat_commit #(
    parameter int ARCH_SZ = 32,
    parameter int PHYS_SZ = 64,
    parameter int N       = 2,
    parameter int PRN_W   = $clog2(PHYS_SZ),
    parameter int ARN_W   = $clog2(ARCH_SZ),
    parameter int CTR_W   = $clog2(PHYS_SZ) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N-1:0]               ct_valid,
    input  logic [N*ARN_W-1:0]         ct_dest_arn,
    input  logic [N*PRN_W-1:0]         ct_dest_prn,
    input  logic [N-1:0]               ct_squash,
    output logic [N-1:0]               free_valid,
    output logic [N*PRN_W-1:0]         free_prn,
    output logic                       squash,
    output logic [ARCH_SZ*PRN_W-1:0]   rrat_table,
    output logic [PHYS_SZ*PRN_W-1:0]   fl_list,
    output logic [PRN_W-1:0]           fl_head,
    output logic [PRN_W-1:0]           fl_tail,
    output logic [CTR_W-1:0]           fl_counter
);

    localparam int FREE_INIT = PHYS_SZ - ARCH_SZ;

    logic [PRN_W-1:0] table_q [ARCH_SZ];
    logic [PRN_W-1:0] table_d [ARCH_SZ];
    logic [PRN_W-1:0] list_q  [PHYS_SZ];
    logic [PRN_W-1:0] list_d  [PHYS_SZ];
    logic [PRN_W-1:0] head_q, head_d;
    logic [PRN_W-1:0] tail_q, tail_d;
    logic [CTR_W-1:0] counter_q, counter_d;
    logic [N-1:0]     free_valid_q, free_valid_d;
    logic [PRN_W-1:0] free_prn_q [N];
    logic [PRN_W-1:0] free_prn_d [N];
    logic             squash_q, squash_d;

    logic             contig;
    logic             stop;
    logic             live;
    logic             pop_ok;
    logic [ARN_W-1:0] lane_arn;
    logic [PRN_W-1:0] lane_prn;
    logic [PRN_W-1:0] old_prn;
    int unsigned      upd_cnt;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PRN_W-1:0] wrap_add(input logic [PRN_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(PHYS_SZ)) begin
            sum = sum - 32'(PHYS_SZ);
        end
        return sum[PRN_W-1:0];
    endfunction

    // Lanes are walked in order; table_d carries earlier lanes' writes so same-arn lanes chain.
    always_comb begin
        table_d      = table_q;
        list_d       = list_q;
        free_valid_d = '0;
        for (int i = 0; i < N; i++) begin
            free_prn_d[i] = '0;
        end
        squash_d  = 1'b0;
        contig    = 1'b1;
        stop      = 1'b0;
        live      = 1'b0;
        pop_ok    = 1'b1;
        lane_arn  = '0;
        lane_prn  = '0;
        old_prn   = '0;
        upd_cnt   = 0;
        for (int i = 0; i < N; i++) begin
            lane_arn = ct_dest_arn[i*ARN_W +: ARN_W];
            lane_prn = ct_dest_prn[i*PRN_W +: PRN_W];
            if (!ct_valid[i]) begin
                contig = 1'b0;
            end
            live = contig && !stop;
            if (live && (lane_arn != '0)) begin
                old_prn            = table_d[lane_arn];
                table_d[lane_arn]  = lane_prn;
                list_d[wrap_add(tail_q, upd_cnt)] = old_prn;
                if (list_q[wrap_add(head_q, upd_cnt)] != lane_prn) begin
                    pop_ok = 1'b0;
                end
                free_valid_d[i] = 1'b1;
                free_prn_d[i]   = old_prn;
                upd_cnt         = upd_cnt + 1;
            end
            if (live && ct_squash[i]) begin
                squash_d = 1'b1;
                stop     = 1'b1;
            end
        end
        // Released PRNs already sit in the committed list that rename restores from.
        if (squash_d) begin
            free_valid_d = '0;
        end
        head_d    = wrap_add(head_q, upd_cnt);
        tail_d    = wrap_add(tail_q, upd_cnt);
        counter_d = counter_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_SZ; i++) begin
                table_q[i] <= PRN_W'(i);
            end
            for (int j = 0; j < PHYS_SZ; j++) begin
                list_q[j] <= (j < FREE_INIT) ? PRN_W'(ARCH_SZ + j) : '0;
            end
            head_q       <= '0;
            tail_q       <= PRN_W'(FREE_INIT);
            counter_q    <= CTR_W'(FREE_INIT);
            free_valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                free_prn_q[i] <= '0;
            end
            squash_q     <= 1'b0;
        end else begin
            table_q      <= table_d;
            list_q       <= list_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            counter_q    <= counter_d;
            free_valid_q <= free_valid_d;
            free_prn_q   <= free_prn_d;
            squash_q     <= squash_d;
        end
    end

    // Rename and retire must pop the free list in the same order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (pop_ok);
            assert (counter_q == CTR_W'(FREE_INIT));
        end
    end

    always_comb begin
        rrat_table = '0;
        fl_list    = '0;
        free_prn   = '0;
        for (int i = 0; i < ARCH_SZ; i++) begin
            rrat_table[i*PRN_W +: PRN_W] = table_q[i];
        end
        for (int j = 0; j < PHYS_SZ; j++) begin
            fl_list[j*PRN_W +: PRN_W] = list_q[j];
        end
        for (int i = 0; i < N; i++) begin
            free_prn[i*PRN_W +: PRN_W] = free_prn_q[i];
        end
    end

    assign free_valid = free_valid_q;
    assign squash     = squash_q;
    assign fl_head    = head_q;
    assign fl_tail    = tail_q;
    assign fl_counter = counter_q;

endmodule
